// File: rtl/isa_pkg.sv
// Shared instruction-set definitions: field layout, encode/decode helpers and loader states.
package isa_pkg;
  localparam int INSTR_W = 32;
  localparam int OPC_W   = 4;
  localparam int REG_W   = 5;
  localparam int OFF_W   = 13;

  localparam int OPC_LSB = 0;
  localparam int RD_LSB  = 4;
  localparam int RA_LSB  = 9;
  localparam int RB_LSB  = 14;
  localparam int OFF_LSB = 19;

  typedef enum logic [1:0] {IDLE, LOAD, DRAIN, DONE} load_state_e;

  function automatic logic [INSTR_W-1:0] encode_instr(
    input logic [OPC_W-1:0] opcode,
    input logic [REG_W-1:0] reg_d,
    input logic [REG_W-1:0] reg_a,
    input logic [REG_W-1:0] reg_b,
    input logic [OFF_W-1:0] offset
  );
    return {offset, reg_b, reg_a, reg_d, opcode};
  endfunction

  function automatic logic [OPC_W-1:0] decode_opcode(input logic [INSTR_W-1:0] instr);
    return instr[OPC_LSB +: OPC_W];
  endfunction

  function automatic logic [REG_W-1:0] decode_reg_d(input logic [INSTR_W-1:0] instr);
    return instr[RD_LSB +: REG_W];
  endfunction

  function automatic logic [REG_W-1:0] decode_reg_a(input logic [INSTR_W-1:0] instr);
    return instr[RA_LSB +: REG_W];
  endfunction

  function automatic logic [REG_W-1:0] decode_reg_b(input logic [INSTR_W-1:0] instr);
    return instr[RB_LSB +: REG_W];
  endfunction

  function automatic logic [OFF_W-1:0] decode_offset(input logic [INSTR_W-1:0] instr);
    return instr[OFF_LSB +: OFF_W];
  endfunction
endpackage

// File: rtl/instr_fifo.sv
// Small synchronous FIFO; pointers carry an extra MSB so full and empty are distinguishable.
module instr_fifo #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              full,
  output logic              empty
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]      rd_ptr_q, rd_ptr_d;
  logic [DATA_W-1:0]   mem_q [DEPTH];
  logic                do_push, do_pop;

  always_comb begin
    empty    = (wr_ptr_q == rd_ptr_q);
    full     = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
               (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    do_push  = push && !full;
    do_pop   = pop && !empty;
    wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = do_pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage is not reset; the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[PTR_W-1:0]] <= wdata;
  end

  assign rdata = mem_q[rd_ptr_q[PTR_W-1:0]];
endmodule

// File: rtl/instr_encode_loader.sv
// Packs incoming instruction fields into words and streams them to consecutive
// instruction-memory addresses through a small FIFO.
module instr_encode_loader
  import isa_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter int ADDR_W    = 8,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OPC_W-1:0]  in_opcode,
  input  logic [REG_W-1:0]  in_reg_d,
  input  logic [REG_W-1:0]  in_reg_a,
  input  logic [REG_W-1:0]  in_reg_b,
  input  logic [OFF_W-1:0]  in_offset,
  input  logic              in_last,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ready,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   count,
  output logic              overflow_err
);
  localparam logic [ADDR_W-1:0] BASE_A = ADDR_W'(BASE_ADDR);

  load_state_e         state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ADDR_W:0]     count_q, count_d;
  logic                ovf_q, ovf_d;
  logic                fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [INSTR_W-1:0]  fifo_rdata;

  instr_fifo #(.DEPTH(DEPTH), .DATA_W(INSTR_W)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata (encode_instr(in_opcode, in_reg_d, in_reg_a, in_reg_b, in_offset)),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    count_d   = count_q;
    ovf_d     = ovf_q;
    in_ready  = 1'b0;
    fifo_push = 1'b0;
    done      = 1'b0;
    busy      = (state_q == LOAD) || (state_q == DRAIN);
    mem_we    = busy && !fifo_empty;
    fifo_pop  = mem_we && mem_ready;

    if (fifo_pop) begin
      addr_d  = addr_q + 1'b1;
      count_d = count_q + 1'b1;
      if (addr_q == '1) ovf_d = 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = LOAD;
          addr_d  = BASE_A;
          count_d = '0;
          ovf_d   = 1'b0;
        end
      end
      LOAD: begin
        in_ready  = !fifo_full;
        fifo_push = in_valid && in_ready;
        if (fifo_push && in_last) state_d = DRAIN;
      end
      // Empty is registered, so DONE always follows the cycle after the last pop.
      DRAIN: begin
        if (fifo_empty) state_d = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= BASE_A;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  assign mem_addr     = addr_q;
  assign mem_wdata    = mem_we ? fifo_rdata : '0;
  assign count        = count_q;
  assign overflow_err = ovf_q;
endmodule

// File: tb/tb_instr_encode_loader.sv
// Scoreboard bench: two loaders (default and a narrow wrapping one) share stimulus.
module tb_instr_encode_loader;
  import isa_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        start_m, start_w;
  logic        in_valid, in_last, mem_ready;
  logic [3:0]  in_opcode;
  logic [4:0]  in_reg_d, in_reg_a, in_reg_b;
  logic [12:0] in_offset;

  logic        m_in_ready, m_we, m_busy, m_done, m_ovf;
  logic [7:0]  m_addr;
  logic [31:0] m_wdata;
  logic [8:0]  m_count;

  logic        w_in_ready, w_we, w_busy, w_done, w_ovf;
  logic [1:0]  w_addr;
  logic [31:0] w_wdata;
  logic [2:0]  w_count;

  int pass_cnt = 0;
  int total_cnt = 0;
  int m_done_cnt = 0;
  logic [39:0] exp_m[$];
  logic [39:0] exp_w[$];
  logic [31:0] last_m_wdata;

  always #5 clk = ~clk;

  instr_encode_loader #(.DEPTH(4), .ADDR_W(8), .BASE_ADDR(0)) dut_m (
    .clk(clk), .reset(reset), .start(start_m), .in_valid(in_valid), .in_ready(m_in_ready),
    .in_opcode(in_opcode), .in_reg_d(in_reg_d), .in_reg_a(in_reg_a), .in_reg_b(in_reg_b),
    .in_offset(in_offset), .in_last(in_last), .mem_we(m_we), .mem_addr(m_addr),
    .mem_wdata(m_wdata), .mem_ready(mem_ready), .busy(m_busy), .done(m_done),
    .count(m_count), .overflow_err(m_ovf)
  );

  instr_encode_loader #(.DEPTH(4), .ADDR_W(2), .BASE_ADDR(2)) dut_w (
    .clk(clk), .reset(reset), .start(start_w), .in_valid(in_valid), .in_ready(w_in_ready),
    .in_opcode(in_opcode), .in_reg_d(in_reg_d), .in_reg_a(in_reg_a), .in_reg_b(in_reg_b),
    .in_offset(in_offset), .in_last(in_last), .mem_we(w_we), .mem_addr(w_addr),
    .mem_wdata(w_wdata), .mem_ready(mem_ready), .busy(w_busy), .done(w_done),
    .count(w_count), .overflow_err(w_ovf)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // Monitor for the default loader: scoreboard pop plus stall-stability check.
  logic        m_stall = 1'b0;
  logic [7:0]  m_stall_addr;
  logic [31:0] m_stall_data;
  always @(negedge clk) begin
    logic [39:0] e;
    if (m_done) m_done_cnt++;
    if (m_stall) begin
      check("m_stall_addr", {24'd0, m_addr}, {24'd0, m_stall_addr});
      check("m_stall_wdata", m_wdata, m_stall_data);
    end
    m_stall      = m_we && !mem_ready && !reset;
    m_stall_addr = m_addr;
    m_stall_data = m_wdata;
    if (m_we && mem_ready) begin
      if (exp_m.size() == 0) begin
        total_cnt++;
        $display("FAIL m_unexpected_write: addr %h data %h, none expected", m_addr, m_wdata);
      end else begin
        e = exp_m.pop_front();
        check("m_addr", {24'd0, m_addr}, {24'd0, e[39:32]});
        check("m_wdata", m_wdata, e[31:0]);
        last_m_wdata = m_wdata;
      end
    end
  end

  // Monitor for the wrapping loader; also checks the overflow flag right after the write to 3.
  logic w_after3 = 1'b0;
  always @(negedge clk) begin
    logic [39:0] e;
    if (w_after3) check("w_ovf_after_addr3", {31'd0, w_ovf}, 32'd1);
    w_after3 = 1'b0;
    if (w_we && mem_ready) begin
      if (exp_w.size() == 0) begin
        total_cnt++;
        $display("FAIL w_unexpected_write: addr %h data %h, none expected", w_addr, w_wdata);
      end else begin
        e = exp_w.pop_front();
        check("w_addr", {30'd0, w_addr}, {24'd0, e[39:32]});
        check("w_wdata", w_wdata, e[31:0]);
        w_after3 = (w_addr == 2'd3);
      end
    end
  end

  task automatic pulse_start(input bit sel);
    @(posedge clk); #1;
    if (sel) start_w = 1'b1; else start_m = 1'b1;
    @(posedge clk); #1;
    start_w = 1'b0;
    start_m = 1'b0;
  endtask

  task automatic send(input bit sel, input logic [3:0] op, input logic [4:0] rd,
                      input logic [4:0] ra, input logic [4:0] rb, input logic [12:0] off,
                      input bit last, input bit track, input logic [7:0] ea,
                      input logic [31:0] ew);
    int n = 0;
    bit rdy = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b1; in_opcode = op; in_reg_d = rd; in_reg_a = ra;
    in_reg_b = rb; in_offset = off; in_last = last;
    while (!rdy && n < 50) begin
      @(negedge clk);
      n++;
      rdy = sel ? w_in_ready : m_in_ready;
    end
    if (!rdy) begin
      total_cnt++;
      $display("FAIL send_timeout: in_ready never rose for word %h", ew);
    end else if (track) begin
      if (sel) exp_w.push_back({ea, ew}); else exp_m.push_back({ea, ew});
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_done(input bit sel);
    int n = 0;
    bit seen = 1'b0;
    while (!seen && n < 100) begin
      @(negedge clk);
      n++;
      seen = sel ? w_done : m_done;
    end
    if (!seen) begin
      total_cnt++;
      $display("FAIL done_timeout: got no done pulse, expected one");
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; start_m = 1'b0; start_w = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    mem_ready = 1'b1; in_opcode = '0; in_reg_d = '0; in_reg_a = '0; in_reg_b = '0;
    in_offset = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", {31'd0, m_in_ready}, 32'd0);
    check("rst_mem_we", {31'd0, m_we}, 32'd0);
    check("rst_mem_addr", {24'd0, m_addr}, 32'd0);
    check("rst_mem_wdata", m_wdata, 32'd0);
    check("rst_busy", {31'd0, m_busy}, 32'd0);
    check("rst_done", {31'd0, m_done}, 32'd0);
    check("rst_count", {23'd0, m_count}, 32'd0);
    check("rst_overflow", {31'd0, m_ovf}, 32'd0);
    check("rst_w_mem_addr", {30'd0, w_addr}, 32'd2);
    @(posedge clk); #1;
    reset = 1'b0;

    // Single word
    pulse_start(0);
    send(0, 4'd0, 5'd1, 5'd3, 5'd2, 13'd0, 1, 1, 8'd0, 32'h0000_8610);
    wait_done(0);
    @(negedge clk);
    check("t1_done_once", m_done_cnt, 32'd1);
    check("t1_done_low", {31'd0, m_done}, 32'd0);
    check("t1_count", {23'd0, m_count}, 32'd1);
    check("t1_busy", {31'd0, m_busy}, 32'd0);

    // Max fields plus round-trip decode
    pulse_start(0);
    send(0, 4'd3, 5'd5, 5'd1, 5'd4, 13'h1FFF, 1, 1, 8'd0, 32'hFFF9_0253);
    wait_done(0);
    @(negedge clk);
    check("t2_count", {23'd0, m_count}, 32'd1);
    check("t2_dec_opcode", {28'd0, decode_opcode(last_m_wdata)}, 32'd3);
    check("t2_dec_reg_d", {27'd0, decode_reg_d(last_m_wdata)}, 32'd5);
    check("t2_dec_reg_a", {27'd0, decode_reg_a(last_m_wdata)}, 32'd1);
    check("t2_dec_reg_b", {27'd0, decode_reg_b(last_m_wdata)}, 32'd4);
    check("t2_dec_offset", {19'd0, decode_offset(last_m_wdata)}, 32'h1FFF);

    // in_valid while idle, then start while loading
    @(posedge clk); #1;
    in_valid = 1'b1; in_opcode = 4'hA;
    repeat (4) @(negedge clk);
    check("t6_idle_in_ready", {31'd0, m_in_ready}, 32'd0);
    check("t6_idle_busy", {31'd0, m_busy}, 32'd0);
    check("t6_idle_count", {23'd0, m_count}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    pulse_start(0);
    send(0, 4'd2, 5'd3, 5'd4, 5'd5, 13'd6, 0, 1, 8'd0, 32'h0031_4832);
    pulse_start(0);
    send(0, 4'd7, 5'd0, 5'd0, 5'd0, 13'd1, 1, 1, 8'd1, 32'h0008_0007);
    wait_done(0);
    @(negedge clk);
    check("t6_count", {23'd0, m_count}, 32'd2);

    // Backpressure: four accepted, fifth blocked until memory drains
    @(posedge clk); #1;
    mem_ready = 1'b0;
    pulse_start(0);
    send(0, 4'd1, 5'd2, 5'd3, 5'd4, 13'd5, 0, 1, 8'd0, 32'h0029_0621);
    send(0, 4'hF, 5'h1F, 5'd0, 5'd0, 13'd0, 0, 1, 8'd1, 32'h0000_01FF);
    send(0, 4'd0, 5'd0, 5'h1F, 5'd0, 13'd0, 0, 1, 8'd2, 32'h0000_3E00);
    send(0, 4'd0, 5'd0, 5'd0, 5'h1F, 13'd0, 0, 1, 8'd3, 32'h0007_C000);
    @(negedge clk);
    check("t3_full_in_ready", {31'd0, m_in_ready}, 32'd0);
    check("t3_stalled_we", {31'd0, m_we}, 32'd1);
    check("t3_stalled_addr", {24'd0, m_addr}, 32'd0);
    repeat (3) @(negedge clk);
    @(posedge clk); #1;
    mem_ready = 1'b1;
    send(0, 4'd0, 5'd0, 5'd0, 5'd0, 13'h1000, 1, 1, 8'd4, 32'h8000_0000);
    wait_done(0);
    @(negedge clk);
    check("t3_count", {23'd0, m_count}, 32'd5);
    check("t3_queue_empty", exp_m.size(), 32'd0);

    // Wrap on the narrow loader
    pulse_start(1);
    @(negedge clk);
    check("t4_start_addr", {30'd0, w_addr}, 32'd2);
    check("t4_start_ovf", {31'd0, w_ovf}, 32'd0);
    send(1, 4'd1, 5'd0, 5'd0, 5'd0, 13'd0, 0, 1, 8'd2, 32'h0000_0001);
    send(1, 4'd2, 5'd0, 5'd0, 5'd0, 13'd0, 0, 1, 8'd3, 32'h0000_0002);
    send(1, 4'd3, 5'd0, 5'd0, 5'd0, 13'd0, 0, 1, 8'd0, 32'h0000_0003);
    send(1, 4'd4, 5'd0, 5'd0, 5'd0, 13'd0, 1, 1, 8'd1, 32'h0000_0004);
    wait_done(1);
    @(negedge clk);
    check("t4_count", {29'd0, w_count}, 32'd4);
    check("t4_overflow", {31'd0, w_ovf}, 32'd1);
    check("t4_queue_empty", exp_w.size(), 32'd0);

    // Reset while draining three buffered words
    pulse_start(0);
    send(0, 4'd9, 5'd0, 5'd0, 5'd0, 13'd0, 0, 1, 8'd0, 32'h0000_0009);
    repeat (3) @(negedge clk);
    @(posedge clk); #1;
    mem_ready = 1'b0;
    send(0, 4'd1, 5'd1, 5'd1, 5'd1, 13'd1, 0, 0, 8'd0, 32'h0);
    send(0, 4'd2, 5'd2, 5'd2, 5'd2, 13'd2, 0, 0, 8'd0, 32'h0);
    send(0, 4'd3, 5'd3, 5'd3, 5'd3, 13'd3, 1, 0, 8'd0, 32'h0);
    @(negedge clk);
    check("t5_pre_busy", {31'd0, m_busy}, 32'd1);
    check("t5_pre_count", {23'd0, m_count}, 32'd1);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    mem_ready = 1'b1;
    @(negedge clk);
    check("t5_mem_we", {31'd0, m_we}, 32'd0);
    check("t5_busy", {31'd0, m_busy}, 32'd0);
    check("t5_count", {23'd0, m_count}, 32'd0);
    check("t5_overflow_w", {31'd0, w_ovf}, 32'd0);
    repeat (10) @(negedge clk);
    check("t5_no_done", m_done_cnt, 32'd4);
    check("t5_no_writes_busy", {31'd0, m_busy}, 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
